ahb2ahb_arbiter: RTL

AHB2AHB_ARBITER -- requirements
Module: ahb2ahb_arbiter

---
 rtl/ahb2ahb_arbiter_pkg.sv | 40 ++++
 rtl/ahb2ahb_arbiter_if.sv | 30 +++
 rtl/ahb2ahb_arbiter_rr_picker.sv | 45 ++++
 rtl/ahb2ahb_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ahb2ahb_arbiter_pkg.sv
// Shared AHB encodings, FSM state type and burst-length decode for the
// AHB bus arbiter and its round-robin picker.
package ahb2ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int HMASTER_W = 4;

    // Beat count of a fixed-length burst; 0 means undefined length (SINGLE/INCR).
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb2ahb_arbiter_if.sv
// Arbiter-side view of the shared AHB bus: requests and muxed control in,
// grant and address-phase owner out.
interface ahb2ahb_arbiter_if #(
    parameter int NUM_MASTER = 4
);
    logic [NUM_MASTER-1:0] HBUSREQ;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic                  HREADY;
    logic [NUM_MASTER-1:0] HGRANT;
    logic [3:0]            HMASTER;

    modport slave (
        input  HBUSREQ,
        input  HTRANS,
        input  HBURST,
        input  HREADY,
        output HGRANT,
        output HMASTER
    );

    modport master (
        output HBUSREQ,
        output HTRANS,
        output HBURST,
        output HREADY,
        input  HGRANT,
        input  HMASTER
    );
endinterface

// File: rtl/ahb2ahb_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after last_i, ascending
// with wrap-around. any_o is low when nobody requests.
module ahb2ahb_rr_picker
    import ahb2ahb_pkg::*;
#(
    parameter int NUM_MASTER = 4
) (
    input  logic [NUM_MASTER-1:0] req_i,
    input  logic [3:0]            last_i,
    output logic [NUM_MASTER-1:0] grant_o,
    output logic [3:0]            idx_o,
    output logic                  any_o
);

    logic [4:0]            cand [NUM_MASTER];
    logic [NUM_MASTER-1:0] sel  [NUM_MASTER];
    logic [NUM_MASTER-1:0] hit;

    // Slot gi holds the candidate at offset gi+1 from last_i; last_i < NUM_MASTER
    // keeps the raw sum below 2*NUM_MASTER so one conditional subtract wraps it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTER; gi++) begin : g_cand
            logic [4:0] raw;
            assign raw      = {1'b0, last_i} + 5'(gi + 1);
            assign cand[gi] = (raw >= 5'(NUM_MASTER)) ? (raw - 5'(NUM_MASTER)) : raw;
            assign sel[gi]  = {{(NUM_MASTER-1){1'b0}}, 1'b1} << cand[gi];
            assign hit[gi]  = |(req_i & sel[gi]);
        end
    endgenerate

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = NUM_MASTER - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant_o = sel[i];
                idx_o   = 4'(cand[i]);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb2ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-burst and INCR locking,
// registered one-hot HGRANT and HMASTER tracking the address-phase owner.
module ahb2ahb_arbiter
    import ahb2ahb_pkg::*;
#(
    parameter int NUM_MASTER     = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb2ahb_arbiter_if.slave  bus
);

    localparam logic [NUM_MASTER-1:0] DEFAULT_GRANT =
        {{(NUM_MASTER-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [3:0] DEFAULT_IDX = 4'(DEFAULT_MASTER);

    arb_state_e            state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic [NUM_MASTER-1:0] hgrant_q,  hgrant_d;
    logic [3:0]            gidx_q,    gidx_d;
    logic [3:0]            hmaster_q, hmaster_d;

    logic [NUM_MASTER-1:0] pick_grant;
    logic [3:0]            pick_idx;
    logic                  pick_any;

    logic [4:0]            blen;
    logic                  nonseq_fixed;
    logic                  owner_req;
    logic                  incr_hold;
    logic                  hold;

    ahb2ahb_rr_picker #(
        .NUM_MASTER (NUM_MASTER)
    ) u_picker (
        .req_i   (bus.HBUSREQ),
        .last_i  (hmaster_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign blen         = burst_len(bus.HBURST);
    assign nonseq_fixed = (bus.HTRANS == HTRANS_NONSEQ) && (blen != 5'd0);
    assign owner_req    = |(bus.HBUSREQ & ({{(NUM_MASTER-1){1'b0}}, 1'b1} << hmaster_q));

    // An undefined-length burst keeps the bus while its owner still asks for it.
    assign incr_hold = (bus.HBURST == HBURST_INCR) &&
                       ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ)) &&
                       owner_req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hgrant_d  = hgrant_q;
        gidx_d    = gidx_q;
        hmaster_d = hmaster_q;
        hold      = 1'b0;

        if (bus.HREADY) begin
            hmaster_d = gidx_q;

            case (state_q)
                ST_ARB: begin
                    if (nonseq_fixed) begin
                        state_d = ST_BURST;
                        cnt_d   = 4'(blen - 5'd1);
                    end
                end
                ST_BURST: begin
                    case (bus.HTRANS)
                        HTRANS_SEQ: begin
                            cnt_d = cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                state_d = ST_ARB;
                            end
                        end
                        HTRANS_BUSY: begin
                        end
                        default: begin
                            // Early termination; a new fixed burst restarts the count.
                            if (nonseq_fixed) begin
                                state_d = ST_BURST;
                                cnt_d   = 4'(blen - 5'd1);
                            end else begin
                                state_d = ST_ARB;
                                cnt_d   = 4'd0;
                            end
                        end
                    endcase
                end
                default: begin
                    state_d = ST_ARB;
                    cnt_d   = 4'd0;
                end
            endcase

            hold = (state_d == ST_BURST) || incr_hold;

            if (!hold) begin
                if (pick_any) begin
                    hgrant_d = pick_grant;
                    gidx_d   = pick_idx;
                end else begin
                    hgrant_d = DEFAULT_GRANT;
                    gidx_d   = DEFAULT_IDX;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_ARB;
            cnt_q     <= 4'd0;
            hgrant_q  <= DEFAULT_GRANT;
            gidx_q    <= DEFAULT_IDX;
            hmaster_q <= DEFAULT_IDX;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hgrant_q  <= hgrant_d;
            gidx_q    <= gidx_d;
            hmaster_q <= hmaster_d;
        end
    end

    assign bus.HGRANT  = hgrant_q;
    assign bus.HMASTER = hmaster_q;

endmodule
